// File: rtl/des_key_schedule.sv
// des_key_schedule
// Sequential DES key-schedule generator. A 64-bit key is reduced by PC-1 into a
// 56-bit C/D register, which is rotated once per round. PC-2 of the register is
// presented as the round subkey under a valid/ready handshake, so the round
// datapath downstream can stall the schedule.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   start         request a new schedule (accepted only while ready=1)
//   key_in[63:0]  DES key, bit 63 = FIPS bit 1, parity bits ignored
//   decrypt       sampled with start: 0 = K1..K16, 1 = K16..K1
//   ready         high while idle
//   subkey[47:0]  PC-2 of the current C/D register, bit 47 = FIPS bit 1
//   subkey_valid  subkey holds round `round`
//   subkey_ready  downstream accepts subkey when subkey_valid & subkey_ready
//   round[4:0]    current round 1..16, 0 while idle
//   done          one-cycle pulse after round 16 has been consumed
module des_key_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  output logic        ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [4:0]  round,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_e;

  // FIPS 46-3 permuted-choice tables, 1-based FIPS bit numbers.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // FIPS bit n of a W-bit vector lives at index W-n.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    logic [5:0]  src;
    logic [5:0]  dst;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      src    = 6'(64 - PC1_TAB[i]);
      dst    = 6'(55 - i);
      r[dst] = k[src];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    logic [5:0]  src;
    logic [5:0]  dst;
    r = '0;
    for (int j = 0; j < 48; j++) begin
      src    = 6'(56 - PC2_TAB[j]);
      dst    = 6'(47 - j);
      r[dst] = cd[src];
    end
    return r;
  endfunction

  // Rotation amount for round r: one position in rounds 1, 2, 9, 16, else two.
  function automatic logic [1:0] shift_amt(input logic [4:0] r);
    return (r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  // C and D rotate independently as two 28-bit rings.
  function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic right,
                                         input logic [1:0] n);
    if (right) return {rotr28(cd[55:28], n), rotr28(cd[27:0], n)};
    else       return {rotl28(cd[55:28], n), rotl28(cd[27:0], n)};
  endfunction

  state_e      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [4:0]  round_q, round_d;
  logic        mode_q, mode_d;
  logic        done_q, done_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    round_d = round_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = decrypt;
          // Encrypt needs C1D1 (left by one); decrypt starts at C16D16 = C0D0.
          cd_d    = decrypt ? pc1(key_in) : rot_cd(pc1(key_in), 1'b0, 2'd1);
          round_d = 5'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (subkey_ready) begin
          if (round_q == 5'd16) begin
            state_d = IDLE;
            round_d = 5'd0;
            done_d  = 1'b1;
          end else begin
            round_d = 5'(round_q + 5'd1);
            // Decrypt undoes the encrypt rotations in reverse order: stepping to
            // round r+1 undoes encrypt round 17-r.
            cd_d    = mode_q ? rot_cd(cd_q, 1'b1, shift_amt(5'd17 - round_q))
                             : rot_cd(cd_q, 1'b0, shift_amt(5'(round_q + 5'd1)));
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cd_q    <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign ready        = ready_q;
  assign subkey_valid = valid_q;
  assign round        = round_q;
  assign done         = done_q;
  assign subkey       = pc2(cd_q);

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: table of schedule runs compared
// against known FIPS subkeys for key 133457799BBCDFF1, plus hand-written
// back-to-back and reset sequences.
module tb_des_key_schedule;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] key_in;
  logic        decrypt;
  logic        ready;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [4:0]  round;
  logic        done;

  des_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .ready        (ready),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round        (round),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] KEY_A    = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_ONES = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] KEY_ZERO = 64'h0000000000000000;

  // kind: 0 = KEY_A known subkeys, 1 = all-zero subkeys, 2 = all-one subkeys
  // mode: 0 = free-running, 1 = backpressure, 2 = stray start at round 5 + reset at round 9
  typedef struct {
    logic [63:0] key;
    logic        dec;
    int          kind;
    int          mode;
  } vec_t;

  logic [47:0] kt [1:16];
  vec_t        vecs [5];
  int          n_checks;
  int          n_errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] exp_sub(input int kind, input logic dec, input int r);
    case (kind)
      0:       return dec ? kt[17 - r] : kt[r];
      1:       return 48'h000000000000;
      default: return 48'hFFFFFFFFFFFF;
    endcase
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, " ready"}, 64'(ready), 64'd1);
    chk({tag, " subkey_valid"}, 64'(subkey_valid), 64'd0);
    chk({tag, " round"}, 64'(round), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " subkey"}, 64'(subkey), 64'd0);
  endtask

  // Called at a negedge with start/key_in/decrypt already driven. Returns at the
  // negedge where done should be high (checked), or after the mid-run reset.
  task automatic run_body(input logic dec, input int kind, input int mode);
    int r;
    int cycles;
    int stalls;
    r      = 1;
    cycles = 0;
    stalls = 0;
    @(posedge clk);
    @(negedge clk);
    while (r <= 16 && cycles < 200) begin
      start = 1'b0;
      if (mode == 2 && r == 5) begin
        start   = 1'b1;
        key_in  = KEY_ONES;
        decrypt = ~dec;
      end
      if (mode == 1) begin
        if (r == 2 && stalls < 3) begin
          subkey_ready = 1'b0;
          stalls++;
        end else if (r > 2) begin
          subkey_ready = 1'($urandom_range(0, 1));
        end else begin
          subkey_ready = 1'b1;
        end
      end else begin
        subkey_ready = 1'b1;
      end
      chk($sformatf("valid r%0d", r), 64'(subkey_valid), 64'd1);
      chk($sformatf("round r%0d", r), 64'(round), 64'(r));
      chk($sformatf("subkey r%0d", r), 64'(subkey), 64'(exp_sub(kind, dec, r)));
      chk($sformatf("no-done r%0d", r), 64'(done), 64'd0);
      chk($sformatf("not-ready r%0d", r), 64'(ready), 64'd0);
      if (mode == 2 && r == 9) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_values("midrun-reset");
        rst = 1'b0;
        return;
      end
      if (subkey_ready) r++;
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    start        = 1'b0;
    subkey_ready = 1'b1;
    chk("handshakes", 64'(r - 1), 64'd16);
    if (mode == 0) chk("consecutive-cycles", 64'(cycles), 64'd16);
    chk("done pulse", 64'(done), 64'd1);
    chk("end valid", 64'(subkey_valid), 64'd0);
    chk("end ready", 64'(ready), 64'd1);
    chk("end round", 64'(round), 64'd0);
  endtask

  initial begin
    kt[1]  = 48'h1B02EFFC7072; kt[2]  = 48'h79AED9DBC9E5;
    kt[3]  = 48'h55FC8A42CF99; kt[4]  = 48'h72ADD6DB351D;
    kt[5]  = 48'h7CEC07EB53A8; kt[6]  = 48'h63A53E507B2F;
    kt[7]  = 48'hEC84B7F618BC; kt[8]  = 48'hF78A3AC13BFB;
    kt[9]  = 48'hE0DBEBEDE781; kt[10] = 48'hB1F347BA464F;
    kt[11] = 48'h215FD3DED386; kt[12] = 48'h7571F59467E9;
    kt[13] = 48'h97C5D1FABA41; kt[14] = 48'h5F43B7F2E73A;
    kt[15] = 48'hBF918D3D3F0A; kt[16] = 48'hCB3D8B0E17F5;

    vecs[0] = '{key: KEY_A,    dec: 1'b0, kind: 0, mode: 0};
    vecs[1] = '{key: KEY_A,    dec: 1'b1, kind: 0, mode: 0};
    vecs[2] = '{key: KEY_A,    dec: 1'b0, kind: 0, mode: 1};
    vecs[3] = '{key: KEY_A,    dec: 1'b0, kind: 0, mode: 2};
    vecs[4] = '{key: KEY_ONES, dec: 1'b0, kind: 2, mode: 0};

    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b1;
    start        = 1'b1;
    key_in       = KEY_A;
    decrypt      = 1'b0;
    subkey_ready = 1'b1;

    // Reset held two cycles with start asserted: nothing may start.
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("post-reset idle");

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("idle done v%0d", i), 64'(done), 64'd0);
      chk($sformatf("idle ready v%0d", i), 64'(ready), 64'd1);
      start   = 1'b1;
      key_in  = vecs[i].key;
      decrypt = vecs[i].dec;
      run_body(vecs[i].dec, vecs[i].kind, vecs[i].mode);
    end

    // Back-to-back: start on the cycle done is high.
    start   = 1'b1;
    key_in  = KEY_ZERO;
    decrypt = 1'b0;
    run_body(1'b0, 1, 0);
    @(negedge clk);
    chk("final done low", 64'(done), 64'd0);
    chk("final ready", 64'(ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
Sequential DES key-schedule generator that produces the 16 round subkeys, one per handshake.
- Accepts a 64-bit key and applies PC-1 to get a 56-bit C/D register.
- Rotates C and D per round, left for encrypt and right for decrypt.
- Applies PC-2 to deliver each 48-bit subkey to the round datapath downstream, which may stall it.
- Replaces the per-round combinational mixer with a single stateful C/D register, so the round function sees one subkey per round.

Parameters:
none (all widths fixed by FIPS 46-3: key 64, C/D 56, subkey 48, round index 5)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request a new schedule; accepted only when ready=1
key_in  input  64  DES key, bit 63 = FIPS bit 1; parity bits (FIPS 8,16,…,64) ignored
decrypt  input  1  sampled with start; 0 = K1..K16 order, 1 = K16..K1 order
ready  output  1  1 in IDLE only
subkey  output  48  PC-2 of current C/D; bit 47 = FIPS bit 1
subkey_valid  output  1  subkey holds round `round`
subkey_ready  input  1  downstream accepts subkey when subkey_valid & subkey_ready
round  output  5  current round index 1..16 (0 in IDLE)
done  output  1  one-cycle pulse after round 16 is consumed

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) forces these values, overriding start and any handshake in the same cycle:
  - state=IDLE, C/D register=0, round=0, subkey_valid=0, done=0, ready=1.
  - subkey = PC2(0) = 0.
- C/D register layout: C = cd[55:28], D = cd[27:0]. Each half rotates independently, 28-bit circular.
- Shift table, by round r: 1 at r ∈ {1,2,9,16}, else 2.
- States: IDLE, RUN.
- IDLE:
  - ready=1.
  - On start=1 the block captures decrypt into a mode flag and loads the C/D register with PC1(key_in) already rotated for round 1. Encrypt: left by 1. Decrypt: rotate 0, since C0D0 = C16D16.
  - Same edge: round<=1, state<=RUN.
- RUN:
  - ready=0, subkey_valid=1, and subkey = PC2(cd) combinationally from the registered cd.
  - Latency: subkey_valid is asserted on the cycle after start is accepted.
  - Handshake at round r<16: round<=r+1 and cd rotates for round r+1.
    - Encrypt: left by shift(r+1).
    - Decrypt: right by shift(17-(r+1)+1), i.e. the right-shift sequence 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 for rounds 1..16.
  - Handshake at round 16: state<=IDLE, subkey_valid<=0, round<=0, done<=1 for exactly one cycle; cd retains its final value.
  - subkey_ready=0 (stall): cd, round and subkey hold; subkey_valid stays 1 indefinitely.
- start while in RUN is ignored, and key_in/decrypt are not sampled.
- start on the same cycle done is high (block already in IDLE) is accepted normally, giving back-to-back schedules with one idle cycle between the last and next valid.
- After a full encrypt schedule the final cd equals the original PC1(key_in), since total left rotation is 28.
- ready and done are registered or decoded from registered state only; there are no combinational paths from inputs to ready, subkey_valid or done.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles, with start=1 held during reset.
  - Required: ready=1, subkey_valid=0, round=0, done=0; no schedule starts.
- Encrypt vector:
  - Stimulus: key_in=64'h133457799BBCDFF1, decrypt=0, subkey_ready=1, start pulse.
  - Required: PC1 gives C0=28'hF0CCAAF, D0=28'h556678F.
  - Required subkeys: round1 = 48'h1B02EFFC7072, round2 = 48'h79AED9DBC9E5, round16 = 48'hCB3D8B0E17F5.
  - Required timing: valid on 16 consecutive cycles; done one cycle after round 16.
- Decrypt vector:
  - Stimulus: same key, decrypt=1.
  - Required: round1 subkey = 48'hCB3D8B0E17F5, round16 = 48'h1B02EFFC7072; all 16 equal the encrypt list reversed.
- Backpressure:
  - Stimulus: encrypt run with subkey_ready low for 3 cycles at round 2, then random toggling.
  - Required: at round 2, subkey stays 48'h79AED9DBC9E5 and round stays 2 while stalled.
  - Required: exactly 16 handshakes total and one done pulse.
- Ignored start and mid-run reset:
  - Stimulus: start with a different key at round 5, then rst=1 at round 9.
  - Required: the round-5 start does not perturb the subkeys.
  - Required: after rst, outputs equal reset values the next cycle; a new start then produces round1 from the new key.
- Back-to-back:
  - Stimulus: start asserted on the cycle done=1, with key 64'h0000000000000000.
  - Required: new schedule begins and all 16 subkeys = 48'h000000000000.
